miner_result_tx: RTL
====================

# miner_result_tx

Downstream stage of `miner`. On each `send_data` pulse it captures the 288-bit result word (`tx_data` = 256-bit hash followed by 32-bit nonce), frames it, and streams it out one byte at a time over a valid/ready handshake to the UART transmitter. It holds one result in flight and queues one more, so back-to-back results from the miner are never lost. Overflow beyond that depth is flagged and counted.

## Interface
- `PAYLOAD_BYTES`, default 36: result word width in bytes; `tx_data` width is 8*PAYLOAD_BYTES.
- `SOF_BYTE`, default 8'hAA: start-of-frame marker.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `send_data`  in  1  single-cycle pulse from `miner`: `tx_data` valid this cycle.
- `tx_data`  in  288  result; bits [287:32] are the hash, [31:0] the nonce.
- `out_byte`  out  8  current byte presented to the UART.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  UART accepts `out_byte` when `out_valid && out_ready`.
- `busy`  out  1  frame in progress or pending slot occupied.
- `overflow`  out  1  one-cycle pulse: a result was dropped.
- `drop_count`  out  8  saturating count of dropped results.

## Operation
- Frame is SOF_BYTE, then 36 payload bytes MSB-first (`tx_data[287:280]` first, `[7:0]` last), then a checksum byte. Total 38 bytes.
- Checksum is the XOR of the 36 payload bytes. SOF is excluded.
- FSM states are IDLE, SOF, PAYLOAD, CSUM.
  - IDLE -> SOF on load.
  - SOF -> PAYLOAD on accept.
  - PAYLOAD stays while byte index < 35. It goes to CSUM when byte 35 is accepted.
  - CSUM -> SOF on accept if the pending slot is full or `send_data` is high that cycle. Otherwise CSUM -> IDLE.
- The active frame lives in a 288-bit shift register, a 6-bit byte index, and a running XOR accumulator. The shift register shifts left 8 bits on each accepted payload byte.
- Pending slot holds one 288-bit word plus a valid bit.
- `send_data` handling, decided in this priority order:
  1. FSM in IDLE, or the CSUM byte is being accepted this cycle with the pending slot empty: load `tx_data` directly into the active register.
  2. The CSUM byte is being accepted with the pending slot full: promote pending to active. The incoming `tx_data` replaces pending, and pending stays full.
  3. Busy and pending empty: capture into pending.
  4. Busy and pending full with no promotion this cycle: drop. Pulse `overflow`; `drop_count` increments and saturates at 255.
- `out_byte` and `out_valid` hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_byte`=0, `out_valid`=0, `busy`=0, `overflow`=0, `drop_count`=0. State is IDLE, pending is empty, accumulator is 0.
- Reset asserted mid-frame aborts the frame and clears pending at the next edge. No partial frame resumes.
- Latency: `send_data` in IDLE at edge N gives SOF on `out_byte` with `out_valid`=1 from cycle N+1.
- With `out_ready` held at 1, a frame takes exactly 38 cycles. A queued frame's SOF follows its predecessor's checksum in the very next cycle, with no idle gap.
- `out_valid` is never deasserted between SOF and checksum of one frame.
- `busy` is registered and rises the cycle after the load.
- `overflow` is registered and asserts for exactly one cycle, the cycle after the dropped `send_data`.
- `out_ready` is ignored while `out_valid`=0.

## Structure
- Package `miner_pkg` holds:
  - `PAYLOAD_BYTES`, `SOF_BYTE`.
  - `result_t` (packed struct: `logic [255:0] hash; logic [31:0] nonce;`).
  - enum `tx_state_t` {IDLE, SOF, PAYLOAD, CSUM}.
- No sub-module needed. The FSM, shift register, and pending slot sit in one module.

## Test plan
- Byte order and checksum:
  - Stimulus: reset, then `out_ready`=1; `send_data` with `tx_data` = 256'h0 followed by 32'h12345678.
  - Required: bytes AA, 32×00, 12, 34, 56, 78, then checksum 08.
  - Required: frame is 38 consecutive valid cycles, starting the cycle after the pulse.
- Backpressure:
  - Stimulus: same frame, `out_ready` toggled pseudo-randomly.
  - Required: identical byte sequence, and `out_byte` never changes while stalled.
- Back-to-back:
  - Stimulus: two `send_data` pulses 3 cycles apart; second word all 8'hFF.
  - Required: the second frame's AA follows the first frame's checksum with no gap.
  - Required: second frame is 36×FF with checksum 00.
- Overflow:
  - Stimulus: three pulses within the first frame.
  - Required: third is dropped, `overflow` pulses once, `drop_count`=1, exactly two frames emitted.
- Simultaneous event:
  - Stimulus: `send_data` in the same cycle the checksum is accepted, pending empty.
  - Required: new frame's SOF the next cycle, and `drop_count` unchanged.
- Reset mid-frame:
  - Stimulus: assert `rst` at payload byte 10 with pending full.
  - Required: next cycle all outputs at reset values.
  - Required: after reset release, a new pulse yields a clean full frame.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and constants for the miner result path.
// Frame geometry, result word layout and transmit FSM states.
// No logic; imported by miner_result_tx.
package miner_pkg;

  localparam int         PAYLOAD_BYTES = 36;
  localparam logic [7:0] SOF_BYTE      = 8'hAA;

  typedef struct packed {
    logic [255:0] hash;
    logic [31:0]  nonce;
  } result_t;

  typedef enum logic [1:0] {
    IDLE,
    SOF,
    PAYLOAD,
    CSUM
  } tx_state_t;

endpackage

// File: rtl/miner_result_tx.sv
// Frames miner results (SOF, payload MSB-first, XOR checksum) into a byte stream.
// Latency: SOF presented the cycle after send_data; 38 cycles per frame at full rate.
// Backpressure: out_byte/out_valid hold while !out_ready; one result queued, further ones dropped.
module miner_result_tx #(
  parameter int         PAYLOAD_BYTES = miner_pkg::PAYLOAD_BYTES,
  parameter logic [7:0] SOF_BYTE      = miner_pkg::SOF_BYTE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send_data,
  input  logic [8*PAYLOAD_BYTES-1:0] tx_data,
  output logic [7:0]                 out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);
  import miner_pkg::*;

  localparam int         W        = 8 * PAYLOAD_BYTES;
  localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_BYTES - 1);

  tx_state_t      state, state_nxt;
  logic [W-1:0]   shreg;
  logic [5:0]     idx;
  logic [7:0]     acc;
  logic [W-1:0]   pend;
  logic           pend_vld, pend_vld_nxt;

  logic           accept;
  logic           load_act;
  logic           load_from_pend;
  logic           pend_wr;
  logic           pend_clr;
  logic           drop;

  assign accept = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_act       = 1'b0;
    load_from_pend = 1'b0;
    pend_wr        = 1'b0;
    pend_clr       = 1'b0;
    drop           = 1'b0;
    case (state)
      IDLE: begin
        if (send_data) begin
          load_act  = 1'b1;
          state_nxt = SOF;
        end
      end
      SOF: begin
        if (accept) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (accept && idx == LAST_IDX) state_nxt = CSUM;
      end
      CSUM: begin
        if (accept) begin
          if (pend_vld) begin
            load_act       = 1'b1;
            load_from_pend = 1'b1;
            state_nxt      = SOF;
            if (send_data) pend_wr  = 1'b1;
            else           pend_clr = 1'b1;
          end else if (send_data) begin
            load_act  = 1'b1;
            state_nxt = SOF;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Results arriving mid-frame either queue or are dropped.
    if (send_data && state != IDLE && !(state == CSUM && accept)) begin
      if (!pend_vld) pend_wr = 1'b1;
      else           drop    = 1'b1;
    end
    pend_vld_nxt = pend_wr ? 1'b1 : (pend_clr ? 1'b0 : pend_vld);
  end

  always_comb begin
    out_byte  = 8'h00;
    out_valid = 1'b0;
    case (state)
      SOF:     begin out_byte = SOF_BYTE;          out_valid = 1'b1; end
      PAYLOAD: begin out_byte = shreg[W-1 -: 8];   out_valid = 1'b1; end
      CSUM:    begin out_byte = acc;               out_valid = 1'b1; end
      default: begin out_byte = 8'h00;             out_valid = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      acc        <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state    <= state_nxt;
      pend_vld <= pend_vld_nxt;
      busy     <= (state_nxt != IDLE) || pend_vld_nxt;
      overflow <= drop;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (pend_wr) pend <= tx_data;
      if (load_act) begin
        shreg <= load_from_pend ? pend : tx_data;
        idx   <= '0;
        acc   <= '0;
      end else if (state == PAYLOAD && accept) begin
        shreg <= shreg << 8;
        idx   <= idx + 6'd1;
        acc   <= acc ^ shreg[W-1 -: 8];
      end
    end
  end

endmodule
